// File: rtl/des_pkg.sv
// Shared types and constants for the DES job controller and its helpers.
package des_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 6;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/des_ctrl_if.sv
// Job request / result channel between a host and the DES controller.
interface des_ctrl_if;
    import des_pkg::*;

    // valid/ready: a transfer completes on a rising edge where both are high;
    // the sender holds valid and its payload stable until that edge.
    logic              req_valid;
    logic              req_ready;
    logic              req_mode;
    logic [ADDR_W-1:0] req_kaddr;
    logic [ADDR_W-1:0] req_maddr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_mode;

    modport slave (
        input  req_valid, req_mode, req_kaddr, req_maddr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_mode
    );

    modport master (
        output req_valid, req_mode, req_kaddr, req_maddr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_mode
    );

endinterface

// File: rtl/des_lat_cnt.sv
// Loadable down-counter; done_o marks the last cycle of a loaded phase.
module des_lat_cnt
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A phase loaded with N stays in that phase for N cycles, the last one flagged.
    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/des_ctrl.sv
// DES job controller: fetch key/message, launch the core, return the result.
// Optional DES_CTRL_PERF_EN adds a 16-bit completed-job counter on job_cnt.
module des_ctrl
    import des_pkg::*;
#(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned CORE_LAT = 17
)
(
    input  logic              clk,
    input  logic              rst_n,
    des_ctrl_if.slave         host,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_add0,
    output logic [ADDR_W-1:0] mem_add1,
    output logic              core_start,
    input  logic [DATA_W-1:0] enc_data,
    input  logic [DATA_W-1:0] dec_data,
    output logic              busy,
    output state_e            dbg_state_o
`ifdef DES_CTRL_PERF_EN
    ,
    output logic [15:0]       job_cnt
`endif
);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] kaddr_q, kaddr_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              start_q, start_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_done;

    // One counter serves both timed phases: loaded with MEM_LAT on accept,
    // reloaded with CORE_LAT on the FETCH->RUN transition.
    des_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        kaddr_d    = kaddr_q;
        maddr_d    = maddr_q;
        rsp_data_d = rsp_data_q;
        start_d    = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        unique case (state_q)
            IDLE: begin
                if (host.req_valid) begin
                    mode_d   = host.req_mode;
                    kaddr_d  = host.req_kaddr;
                    maddr_d  = host.req_maddr;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(MEM_LAT);
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(CORE_LAT);
                    start_d  = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_done) begin
                    rsp_data_d = (mode_q == DEC) ? dec_data : enc_data;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (host.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= ENC;
            kaddr_q    <= '0;
            maddr_q    <= '0;
            rsp_data_q <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            kaddr_q    <= kaddr_d;
            maddr_q    <= maddr_d;
            rsp_data_q <= rsp_data_d;
            start_q    <= start_d;
        end
    end

    assign host.req_ready = (state_q == IDLE);
    assign host.rsp_valid = (state_q == RESP);
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_mode  = mode_q;

    assign mem_en      = (state_q == FETCH);
    assign mem_add0    = mem_en ? kaddr_q : '0;
    assign mem_add1    = mem_en ? maddr_q : '0;
    assign core_start  = start_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

`ifdef DES_CTRL_PERF_EN
    logic [15:0] job_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_cnt_q <= '0;
        end else if ((state_q == RESP) && host.rsp_ready) begin
            job_cnt_q <= job_cnt_q + 16'd1;
        end
    end

    assign job_cnt = job_cnt_q;
`endif

endmodule

// File: tb/tb_des_ctrl.sv
// Directed bench for des_ctrl with a behavioural key/message memory and core stub.
module tb_des_ctrl;
  import des_pkg::*;

  localparam int unsigned MEM_LAT  = 1;
  localparam int unsigned CORE_LAT = 17;

  localparam logic [63:0] K_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] M_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] C_A  = 64'h85E813540F0AB405;
  localparam logic [63:0] K_B  = 64'h00000000FFFFFFFF;
  localparam logic [63:0] M_B  = 64'h1111111122222222;
  localparam logic [63:0] C_B  = 64'h22222222EEEEEEEE;
  localparam logic [63:0] JUNK = 64'hDEADBEEFDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_ctrl_if bus ();
  logic        mem_en;
  logic [5:0]  mem_add0, mem_add1;
  logic        core_start;
  logic [63:0] enc_data = JUNK;
  logic [63:0] dec_data = ~JUNK;
  logic        busy;
  state_e      dbg_state;
`ifdef DES_CTRL_PERF_EN
  logic [15:0] job_cnt;
`endif

  des_ctrl #(.MEM_LAT(MEM_LAT), .CORE_LAT(CORE_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (bus.slave),
    .mem_en      (mem_en),
    .mem_add0    (mem_add0),
    .mem_add1    (mem_add1),
    .core_start  (core_start),
    .enc_data    (enc_data),
    .dec_data    (dec_data),
    .busy        (busy),
    .dbg_state_o (dbg_state)
`ifdef DES_CTRL_PERF_EN
    ,
    .job_cnt     (job_cnt)
`endif
  );

  // ---------------- memory and core stub ----------------
  logic [63:0] mem [0:63];
  logic [63:0] key_r = '0;
  logic [63:0] msg_r = '0;
  int          core_cnt = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      key_r <= mem[mem_add0];
      msg_r <= mem[mem_add1];
    end
  end

  function automatic logic [63:0] stub_enc(input logic [63:0] k, input logic [63:0] m);
    if (k == K_A && m == M_A) return C_A;
    return k ^ {m[31:0], m[63:32]};
  endfunction

  function automatic logic [63:0] stub_dec(input logic [63:0] k, input logic [63:0] m);
    if (k == K_A && m == M_A) return M_A;
    return ~(k ^ m);
  endfunction

  // Outputs carry junk after a launch and turn valid only one cycle before
  // the controller is due to capture them.
  always @(posedge clk) begin
    if (core_start) begin
      core_cnt <= CORE_LAT - 2;
      enc_data <= JUNK;
      dec_data <= ~JUNK;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        enc_data <= stub_enc(key_r, msg_r);
        dec_data <= stub_dec(key_r, msg_r);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic mode, input logic [5:0] ka, input logic [5:0] ma);
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_kaddr = ka;
    bus.req_maddr = ma;
  endtask

  // After acceptance, drop valid and garble the payload; the job must not notice.
  task automatic scramble();
    bus.req_valid = 1'b0;
    bus.req_mode  = ~bus.req_mode;
    bus.req_kaddr = ~bus.req_kaddr;
    bus.req_maddr = ~bus.req_maddr;
  endtask

  // Called at cycle 1 of a job; returns in the first RESP cycle (or on timeout).
  task automatic wait_resp(input string tag, input logic [5:0] ka, input logic [5:0] ma);
    int lat = 1;
    int n_mem = 0;
    int n_start = 0;
    int start_cyc = 0;
    int n_bad = 0;
    logic [5:0] seen_ka = 6'h2A;
    logic [5:0] seen_ma = 6'h15;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      if (mem_en) begin
        n_mem++;
        seen_ka = mem_add0;
        seen_ma = mem_add1;
      end
      if (core_start) begin
        n_start++;
        start_cyc = lat;
      end
      if (bus.req_ready || !busy) n_bad++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(MEM_LAT + CORE_LAT + 1));
    check({tag, "_fetch_cycles"}, 64'(n_mem), 64'(MEM_LAT));
    check({tag, "_kaddr"}, 64'(seen_ka), 64'(ka));
    check({tag, "_maddr"}, 64'(seen_ma), 64'(ma));
    check({tag, "_start_pulses"}, 64'(n_start), 64'd1);
    check({tag, "_start_cycle"}, 64'(start_cyc), 64'(MEM_LAT + 1));
    check({tag, "_busy_ready"}, 64'(n_bad), 64'd0);
    check({tag, "_resp_req_ready"}, 64'(bus.req_ready), 64'd0);
  endtask

  task automatic take_resp(input string tag, input logic mode);
    logic [63:0] exp;
    check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "_rsp_data"}, bus.rsp_data, exp);
    end
    check({tag, "_rsp_mode"}, 64'(bus.rsp_mode), 64'(mode));
  endtask

  // Complete job from IDLE with rsp_ready high; ends one cycle after the handshake.
  task automatic run_simple(input string tag, input logic mode, input logic [5:0] ka,
                            input logic [5:0] ma, input logic [63:0] exp);
    bus.rsp_ready = 1'b1;
    set_req(mode, ka, ma);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    scramble();
    wait_resp(tag, ka, ma);
    take_resp(tag, mode);
    @(posedge clk); #1;
    check({tag, "_valid_fall"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] held;
    int n_seen;
    bus.req_valid = 1'b0;
    bus.req_mode  = ENC;
    bus.req_kaddr = '0;
    bus.req_maddr = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 64'(i) * 64'h0101010101010101;
    mem[0]  = K_A;
    mem[1]  = M_A;
    mem[62] = K_B;
    mem[63] = M_B;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_add0", 64'(mem_add0), 64'd0);
    check("rst_mem_add1", 64'(mem_add1), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", bus.rsp_data, 64'd0);
    check("rst_rsp_mode", 64'(bus.rsp_mode), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);

    // Job A: encrypt, response stalled for 10 cycles with a stray request.
    set_req(ENC, 6'd0, 6'd1);
    exp_q.push_back(C_A);
    @(posedge clk); #1;
    scramble();
    wait_resp("a", 6'd0, 6'd1);
    held = bus.rsp_data;
    check("a_data_early", held, C_A);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) set_req(DEC, 6'd5, 6'd6);
      if (i == 4) bus.req_valid = 1'b0;
      check("stall_valid", 64'(bus.rsp_valid), 64'd1);
      check("stall_data", bus.rsp_data, held);
      check("stall_mode", 64'(bus.rsp_mode), 64'(ENC));
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    take_resp("a", ENC);
    @(posedge clk); #1;
    check("a_valid_fall", 64'(bus.rsp_valid), 64'd0);
    check("a_idle_busy", 64'(busy), 64'd0);
    check("a_idle_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    check("stray_req_ignored", 64'(busy), 64'd0);

    // Job B: decrypt with rsp_ready already high, then job C back-to-back.
    set_req(DEC, 6'd0, 6'd1);
    exp_q.push_back(M_A);
    @(posedge clk); #1;
    scramble();
    wait_resp("b", 6'd0, 6'd1);
    take_resp("b", DEC);
    set_req(ENC, 6'd62, 6'd63);
    exp_q.push_back(C_B);
    @(posedge clk); #1;
    check("b_valid_fall", 64'(bus.rsp_valid), 64'd0);
    check("b2b_idle_busy", 64'(busy), 64'd0);
    check("b2b_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    check("b2b_accept_busy", 64'(busy), 64'd1);
    scramble();
    wait_resp("c", 6'd62, 6'd63);
    take_resp("c", ENC);
    @(posedge clk); #1;
    check("c_valid_fall", 64'(bus.rsp_valid), 64'd0);

    // Job D: reset in the 8th RUN cycle discards it.
    bus.rsp_ready = 1'b0;
    set_req(ENC, 6'd0, 6'd1);
    @(posedge clk); #1;
    scramble();
    repeat (8) @(posedge clk);
    #1;
    check("d_in_run", 64'(dbg_state), 64'(RUN));
    #2 rst_n = 1'b0;
    #1;
    check("d_rst_state", 64'(dbg_state), 64'(IDLE));
    check("d_rst_busy", 64'(busy), 64'd0);
    check("d_rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("d_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("d_rst_rsp_data", bus.rsp_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid || busy) n_seen++;
      @(posedge clk); #1;
    end
    check("d_no_response", 64'(n_seen), 64'd0);

    // Job E: normal job after the aborted one.
    run_simple("e", ENC, 6'd0, 6'd1, C_A);

`ifdef DES_CTRL_PERF_EN
    force dut.job_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.job_cnt_q;
    check("perf_preload", 64'(job_cnt), 64'hFFFE);
    run_simple("p1", ENC, 6'd0, 6'd1, C_A);
    check("perf_1", 64'(job_cnt), 64'hFFFF);
    run_simple("p2", DEC, 6'd0, 6'd1, M_A);
    check("perf_2", 64'(job_cnt), 64'h0000);
    run_simple("p3", ENC, 6'd62, 6'd63, C_B);
    check("perf_3", 64'(job_cnt), 64'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/des_ctrl.md
DES_CTRL -- requirements
Module: des_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1: memory read latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter CORE_LAT, default 17: cycles from core_start to valid core output, legal range 1..63.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1: job request present.
REQ-006 SHALL have port req_ready, output, 1: controller accepts a job.
REQ-007 SHALL have port req_mode, input, 1: 0 = encrypt, 1 = decrypt.
REQ-008 SHALL have ports req_kaddr and req_maddr, input, 6 each: key and message word addresses.
REQ-009 SHALL have port mem_en, output, 1: memory read enable.
REQ-010 SHALL have ports mem_add0 and mem_add1, output, 6 each: key and message read addresses.
REQ-011 SHALL have port core_start, output, 1: one-cycle launch pulse to the DES core.
REQ-012 SHALL have ports enc_data and dec_data, input, 64 each: core encrypt and decrypt outputs.
REQ-013 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 64) and rsp_mode (output, 1): result handshake.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> FETCH -> RUN -> RESP -> IDLE.
REQ-016 In IDLE: req_ready=1; on req_valid=1, SHALL latch req_mode, req_kaddr and req_maddr, then enter FETCH.
REQ-017 req_ready SHALL be 0 outside IDLE, and req_valid SHALL be ignored there.
REQ-018 In FETCH: mem_en=1 and mem_add0/mem_add1 = latched addresses for exactly MEM_LAT cycles; then enter RUN.
REQ-019 On RUN entry: core_start=1 for exactly one cycle; a counter then counts CORE_LAT cycles.
REQ-020 At the end of RUN: SHALL capture enc_data if mode=0, else dec_data, into rsp_data, then enter RESP.
REQ-021 In RESP: rsp_valid=1, with rsp_data and rsp_mode stable until rsp_ready=1.
REQ-022 On the cycle rsp_valid & rsp_ready: SHALL return to IDLE, and rsp_valid SHALL fall on the next cycle.
REQ-023 rsp_ready held high before RESP SHALL have no effect.
REQ-024 Job latency from acceptance to rsp_valid SHALL be MEM_LAT+CORE_LAT+1 cycles; at defaults, acceptance at cycle 0 gives rsp_valid at cycle 19.
REQ-025 Back-to-back jobs: a job SHALL be accepted in the cycle after the RESP handshake, at the earliest.
REQ-026 Mid-job changes on req_* SHALL NOT affect the job in flight.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE and clear all counters.
REQ-028 Reset values: req_ready=1, mem_en=0, mem_add0=0, mem_add1=0, core_start=0, rsp_valid=0, rsp_data=0, rsp_mode=0, busy=0.
REQ-029 Reset during FETCH, RUN or RESP SHALL discard the job with no response.

Configuration
REQ-030 With DES_CTRL_PERF_EN defined: SHALL add output job_cnt, 16 bits, reset 0, incremented on each RESP handshake, wrapping 0xFFFF -> 0x0000.
REQ-031 Without DES_CTRL_PERF_EN: port job_cnt and its logic SHALL be absent.

Structure
REQ-032 Package des_pkg SHALL hold: the state enum, the mode constants ENC=0 and DEC=1, address width 6, and data width 64.
REQ-033 Sub-module des_lat_cnt SHALL be used for the FETCH and RUN phases: loadable down-counter with a done flag, instantiated once and reloaded per phase.

Verification
REQ-034 Reset then idle: all outputs at REQ-028 values; busy=0.
REQ-035 Memory key@0x00=133457799BBCDFF1, msg@0x01=0123456789ABCDEF; encrypt job kaddr=0, maddr=1 -> rsp_data=85E813540F0AB405 and rsp_mode=0 at cycle 19.
REQ-036 Same job with mode=1 -> rsp_data = core dec_data = 0123456789ABCDEF.
REQ-037 rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stable; req_ready=0 throughout; a req_valid pulse in this window is ignored.
REQ-038 rst_n pulsed low at cycle 8 of RUN -> immediate IDLE, no rsp_valid; a new job then completes normally.
REQ-039 With DES_CTRL_PERF_EN and job_cnt preloaded to 0xFFFE by force, three jobs -> job_cnt = 0xFFFF, 0x0000, 0x0001.
